operand_forward_unit: RTL and testbench
=======================================

// Module: operand_forward_unit
// PURPOSE
//  Parametrised EX-stage operand bypass for the pipelined MIPS core; replaces the fixed 3-way ALU input mux.
//  Tracks in-flight destination tags for NSTG post-EX stages, selects the youngest matching result for each of NSRC operands.
//  Raises load-use stall when the matching producer is a load whose data is not yet available.
// PARAMETERS
//  DW     32  data width
//  AW     5   register address width; address 0 is hardwired zero, never forwarded
//  NSRC   2   number of source operands (channels)
//  NSTG   2   tracked stages after EX (1 = MEM ... NSTG = WB); NSTG >= 1
//  LD_RDY 2   first stage index at which load data is valid on stg_data; 1 <= LD_RDY <= NSTG
// PORTS
//  clk       in   1        clock, rising edge
//  rst       in   1        asynchronous reset, active-high
//  hold      in   1        global pipeline freeze; tag pipe holds all stages
//  ex_valid  in   1        EX holds a real instruction
//  ex_flush  in   1        kill EX instruction; bubble enters stage 1
//  ex_wen    in   1        EX instruction writes a register
//  ex_load   in   1        EX instruction is a load
//  ex_dst    in   AW       EX destination register
//  src_addr  in   NSRC*AW  source register addresses, operand i at [i*AW +: AW]
//  bus       in   NSRC*DW  register-file read data per operand
//  stg_data  in   NSTG*DW  result data of stage k (1-based) at [(k-1)*DW +: DW]
//  opnd      out  NSRC*DW  forwarded operands
//  fwd_sel   out  NSRC*SW  per-operand select: 0 = bus, k = stage k; SW = clog2(NSTG+1)
//  stall     out  1        load-use stall request to hazard control
// BEHAVIOUR
//  Tag pipe: NSTG entries {v, wen, load, dst}. Reset clears every v; hence opnd = bus, fwd_sel = 0, stall = 0.
//  Per clk edge, when hold = 0: entry k <= entry k-1 for k >= 2; entry 1 <= EX tag if ex_valid & ~ex_flush & ~stall, else bubble (v=0).
//  hold = 1: no entry changes, including with ex_flush; flush must be re-asserted after hold drops.
//  Match(i,k) = v[k] & wen[k] & dst[k] == src_addr[i] & src_addr[i] != 0.
//  Select: smallest k with Match wins (youngest producer); none -> bus. Combinational, zero-cycle latency from tag state.
//  Load hazard(i): winning k has load[k] = 1 and k < LD_RDY -> opnd[i] undefined-but-held to bus value, stall = 1.
//    An older ready match is NOT used when a younger unready load matches.
//  stall = OR over operands of load hazard; while stall = 1 the bubble rule above advances the load one stage per cycle.
//  Stall length = LD_RDY - k cycles; with defaults a load directly ahead costs exactly 1 cycle.
//  Both operands naming the same register resolve identically; r0 always returns bus (0 from regfile).
//  Reset mid-operation: all in-flight tags discarded asynchronously; no partial forward after release.
// CONFIGURATION
//  FWD_STATS_EN defined: adds output stall_cnt [31:0]; +1 each clk with stall & ~hold, saturates at 32'hFFFF_FFFF, reset to 0.
//  FWD_STATS_EN undefined: port and counter absent; behaviour otherwise identical.
// STRUCTURE
//  fwd_pkg: tag struct typedef {v, wen, load, dst}, SW localparam function clog2, select encoding 0 = bus.
//  Sub-module fwd_operand_sel: one operand's priority match/mux/hazard; instantiated NSRC times via generate.
//  Tag pipe and optional stats counter stay in the top module.
// TESTING
//  1 rst high, bus = {32'h11,32'h22} -> opnd = {32'h11,32'h22}, fwd_sel = 0, stall = 0.
//  2 EX: add r5 (wen), next cycle src0 = r5, stg_data[stage1] = 32'hA5 -> opnd0 = 32'hA5, fwd_sel0 = 1.
//  3 r5 written in stages 1 and 2 (32'h1, 32'h2), src1 = r5 -> opnd1 = 32'h1 (youngest).
//  4 lw r7 then src0 = r7 -> stall = 1 one cycle, entry1 bubble; next cycle opnd0 = stg_data[stage2], stall = 0.
//  5 src0 = r0 with stage1 dst = r0, wen = 1 -> opnd0 = bus, fwd_sel0 = 0.
//  6 hold = 1 with ex_flush = 1 over 3 cycles -> tags unchanged; FWD_STATS_EN: stall_cnt frozen while hold.

Source files
------------

// File: rtl/fwd_pkg.sv
// fwd_pkg: shared types and helpers for the EX-stage operand forwarding unit.
//   fwd_tag_t   : one in-flight destination tag {v, wen, load, dst}
//   TAG_BUBBLE  : empty tag pushed into the pipe for flushed/stalled/idle slots
//   SEL_BUS     : select encoding meaning "use register-file data"
//   fwd_clog2() : elaboration-time ceil(log2(n)) used to size the select field
package fwd_pkg;

    // Widest register address a tag can hold; narrower addresses are
    // zero-extended on the way in so comparisons stay exact.
    localparam int TAG_AW = 8;

    // Select value 0 means the register-file bus; k means stage k.
    localparam int SEL_BUS = 0;

    typedef struct packed {
        logic              v;
        logic              wen;
        logic              load;
        logic [TAG_AW-1:0] dst;
    } fwd_tag_t;

    localparam fwd_tag_t TAG_BUBBLE = '0;

    function automatic int fwd_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fwd_operand_sel.sv
// fwd_operand_sel: priority match, data mux and load-use hazard detection for
// one source operand.
// Ports:
//   tags      in   NSTG tags, stage k (1-based) at index k-1
//   src_addr  in   AW   source register address of this operand
//   bus       in   DW   register-file read data for this operand
//   stg_data  in   NSTG*DW result data, stage k at [(k-1)*DW +: DW]
//   opnd      out  DW   forwarded operand
//   fwd_sel   out  SW   0 = bus, k = stage k
//   hazard    out  1    youngest producer is a load whose data is not ready
module fwd_operand_sel
    import fwd_pkg::*;
#(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int NSTG   = 2,
    parameter int LD_RDY = 2,
    parameter int SW     = 2
) (
    input  fwd_tag_t [NSTG-1:0]    tags,
    input  logic [AW-1:0]          src_addr,
    input  logic [DW-1:0]          bus,
    input  logic [NSTG*DW-1:0]     stg_data,
    output logic [DW-1:0]          opnd,
    output logic [SW-1:0]          fwd_sel,
    output logic                   hazard
);

    logic [TAG_AW-1:0] src_ext;
    logic [DW-1:0]     win_data;
    logic [SW-1:0]     win_sel;
    logic              win_unready;

    assign src_ext = TAG_AW'(src_addr);

    // Scan oldest to youngest so the last hit (smallest k) wins. r0 never
    // matches, so it always falls through to the bus.
    always_comb begin
        win_data    = bus;
        win_sel     = SW'(SEL_BUS);
        win_unready = 1'b0;
        for (int k = NSTG; k >= 1; k--) begin
            if (tags[k-1].v && tags[k-1].wen && (tags[k-1].dst == src_ext) &&
                (src_addr != '0)) begin
                win_data    = stg_data[(k-1)*DW +: DW];
                win_sel     = SW'(k);
                win_unready = tags[k-1].load && (k < LD_RDY);
            end
        end
    end

    // A younger unready load masks any older ready match: the operand is
    // parked on the bus value until the load reaches a ready stage.
    assign hazard  = win_unready;
    assign opnd    = win_unready ? bus : win_data;
    assign fwd_sel = win_unready ? SW'(SEL_BUS) : win_sel;

endmodule

// File: rtl/operand_forward_unit.sv
// operand_forward_unit: parametrised EX-stage operand bypass. Tracks the
// destination tags of NSTG post-EX stages and forwards the youngest matching
// result to each of NSRC operands, requesting a stall on load-use hazards.
// Optional feature macro: FWD_STATS_EN adds a saturating stall counter output.
// Ports:
//   clk, rst   clock (rising edge), asynchronous active-high reset
//   hold       global freeze: tag pipe holds every stage
//   ex_valid   EX holds a real instruction
//   ex_flush   kill EX instruction (bubble enters stage 1)
//   ex_wen     EX instruction writes a register
//   ex_load    EX instruction is a load
//   ex_dst     EX destination register
//   src_addr   NSRC source addresses, operand i at [i*AW +: AW]
//   bus        NSRC register-file read values, operand i at [i*DW +: DW]
//   stg_data   NSTG stage results, stage k at [(k-1)*DW +: DW]
//   opnd       NSRC forwarded operands
//   fwd_sel    NSRC selects (0 = bus, k = stage k), SW bits each
//   stall      load-use stall request
//   stall_cnt  (FWD_STATS_EN only) stall cycles seen while not held, saturating
module operand_forward_unit
    import fwd_pkg::*;
#(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int NSRC   = 2,
    parameter int NSTG   = 2,
    parameter int LD_RDY = 2,
    localparam int SW    = fwd_clog2(NSTG + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hold,
    input  logic                 ex_valid,
    input  logic                 ex_flush,
    input  logic                 ex_wen,
    input  logic                 ex_load,
    input  logic [AW-1:0]        ex_dst,
    input  logic [NSRC*AW-1:0]   src_addr,
    input  logic [NSRC*DW-1:0]   bus,
    input  logic [NSTG*DW-1:0]   stg_data,
    output logic [NSRC*DW-1:0]   opnd,
    output logic [NSRC*SW-1:0]   fwd_sel,
    output logic                 stall
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);

    fwd_tag_t [NSTG-1:0] tag_q, tag_d;
    fwd_tag_t            ex_tag;
    logic [NSRC-1:0]     hazard;

    always_comb begin
        ex_tag      = TAG_BUBBLE;
        ex_tag.v    = 1'b1;
        ex_tag.wen  = ex_wen;
        ex_tag.load = ex_load;
        ex_tag.dst  = TAG_AW'(ex_dst);
    end

    // Tag pipe: shifts one stage per unheld cycle. A stalled EX instruction
    // must not enter, so stall injects a bubble and lets the load advance.
    always_comb begin
        tag_d = tag_q;
        if (!hold) begin
            for (int k = NSTG - 1; k >= 1; k--) begin
                tag_d[k] = tag_q[k-1];
            end
            tag_d[0] = (ex_valid && !ex_flush && !stall) ? ex_tag : TAG_BUBBLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

    for (genvar i = 0; i < NSRC; i++) begin : g_opnd
        fwd_operand_sel #(
            .DW     (DW),
            .AW     (AW),
            .NSTG   (NSTG),
            .LD_RDY (LD_RDY),
            .SW     (SW)
        ) u_sel (
            .tags     (tag_q),
            .src_addr (src_addr[i*AW +: AW]),
            .bus      (bus[i*DW +: DW]),
            .stg_data (stg_data),
            .opnd     (opnd[i*DW +: DW]),
            .fwd_sel  (fwd_sel[i*SW +: SW]),
            .hazard   (hazard[i])
        );
    end

    assign stall = |hazard;

`ifdef FWD_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !hold && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_operand_forward_unit.sv
// tb_operand_forward_unit: scoreboard bench for operand_forward_unit with
// default parameters. Each cycle the driver sets inputs just after the rising
// edge and pushes the expected outputs; a monitor pops and compares on the
// falling edge.
module tb_operand_forward_unit;

    logic        clk;
    logic        rst;
    logic        hold;
    logic        ex_valid;
    logic        ex_flush;
    logic        ex_wen;
    logic        ex_load;
    logic [4:0]  ex_dst;
    logic [9:0]  src_addr;
    logic [63:0] bus;
    logic [63:0] stg_data;
    logic [63:0] opnd;
    logic [3:0]  fwd_sel;
    logic        stall;
`ifdef FWD_STATS_EN
    logic [31:0] stall_cnt;
`endif

    operand_forward_unit dut (
        .clk      (clk),
        .rst      (rst),
        .hold     (hold),
        .ex_valid (ex_valid),
        .ex_flush (ex_flush),
        .ex_wen   (ex_wen),
        .ex_load  (ex_load),
        .ex_dst   (ex_dst),
        .src_addr (src_addr),
        .bus      (bus),
        .stg_data (stg_data),
        .opnd     (opnd),
        .fwd_sel  (fwd_sel),
        .stall    (stall)
`ifdef FWD_STATS_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] op0;
        logic [31:0] op1;
        logic [1:0]  sel0;
        logic [1:0]  sel1;
        logic        stl;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks;
    int   n_fail;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ex(input logic v, input logic fl, input logic w, input logic ld,
                          input logic [4:0] dst);
        ex_valid = v;
        ex_flush = fl;
        ex_wen   = w;
        ex_load  = ld;
        ex_dst   = dst;
    endtask

    task automatic set_src(input logic [4:0] s0, input logic [4:0] s1);
        src_addr = {s1, s0};
    endtask

    task automatic set_stg(input logic [31:0] d1, input logic [31:0] d2);
        stg_data = {d2, d1};
    endtask

    task automatic push(input string tag, input logic [31:0] op0, input logic [31:0] op1,
                        input logic [1:0] s0, input logic [1:0] s1, input logic st,
                        input logic [31:0] cnt);
        exp_t e;
        e.tag  = tag;
        e.op0  = op0;
        e.op1  = op1;
        e.sel0 = s0;
        e.sel1 = s1;
        e.stl  = st;
        e.cnt  = cnt;
        sb.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk({mon_e.tag, ".opnd0"}, {32'd0, opnd[31:0]},  {32'd0, mon_e.op0});
            chk({mon_e.tag, ".opnd1"}, {32'd0, opnd[63:32]}, {32'd0, mon_e.op1});
            chk({mon_e.tag, ".sel0"},  {62'd0, fwd_sel[1:0]}, {62'd0, mon_e.sel0});
            chk({mon_e.tag, ".sel1"},  {62'd0, fwd_sel[3:2]}, {62'd0, mon_e.sel1});
            chk({mon_e.tag, ".stall"}, {63'd0, stall},        {63'd0, mon_e.stl});
`ifdef FWD_STATS_EN
            chk({mon_e.tag, ".cnt"},   {32'd0, stall_cnt},    {32'd0, mon_e.cnt});
`endif
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst  = 1'b1;
        hold = 1'b0;
        set_ex(0, 0, 0, 0, 5'd0);
        set_src(5'd0, 5'd0);
        bus = {32'h11, 32'h22};
        set_stg(32'h0, 32'h0);

        // Reset state: no tags, operands follow bus even for nonzero sources.
        next_cycle(); set_src(5'd5, 5'd5);
        push("rst", 32'h22, 32'h11, 0, 0, 0, 0);
        next_cycle(); rst = 1'b0; set_src(5'd0, 5'd0);
        push("idle", 32'h22, 32'h11, 0, 0, 0, 0);

        // ALU result forwarded from stage 1, then stage 2.
        next_cycle(); set_ex(1, 0, 1, 0, 5'd5); set_src(5'd0, 5'd0);
        push("add_r5", 32'h22, 32'h11, 0, 0, 0, 0);
        next_cycle(); set_ex(0, 0, 0, 0, 5'd0); set_src(5'd5, 5'd3);
        set_stg(32'hA5, 32'hBB);
        push("fwd_stg1", 32'hA5, 32'h11, 1, 0, 0, 0);
        next_cycle(); set_ex(1, 0, 1, 0, 5'd5); set_src(5'd5, 5'd0);
        push("fwd_stg2", 32'hBB, 32'h11, 2, 0, 0, 0);

        // Same register in both stages: youngest wins for both operands.
        next_cycle(); set_ex(1, 0, 1, 0, 5'd5); set_src(5'd0, 5'd0);
        push("add_r5_again", 32'h22, 32'h11, 0, 0, 0, 0);
        next_cycle(); set_ex(0, 0, 0, 0, 5'd0); set_src(5'd5, 5'd5);
        set_stg(32'h1, 32'h2);
        push("youngest", 32'h1, 32'h1, 1, 1, 0, 0);

        // Load-use: one stall cycle, then forward from stage 2.
        next_cycle(); set_ex(1, 0, 1, 1, 5'd7); set_src(5'd0, 5'd0);
        push("lw_r7", 32'h22, 32'h11, 0, 0, 0, 0);
        next_cycle(); set_ex(1, 0, 1, 0, 5'd9); set_src(5'd7, 5'd0);
        set_stg(32'hDEAD, 32'h77);
        push("load_use", 32'h22, 32'h11, 0, 0, 1, 0);
        next_cycle();
        push("load_fwd", 32'h77, 32'h11, 2, 0, 0, 1);

        // r0 destination is never forwarded; r9 from stage 2 still is.
        next_cycle(); set_ex(1, 0, 1, 0, 5'd0); set_src(5'd0, 5'd0);
        push("r0_issue", 32'h22, 32'h11, 0, 0, 0, 1);
        next_cycle(); set_ex(1, 0, 1, 1, 5'd3); set_src(5'd0, 5'd9);
        set_stg(32'h1234, 32'h99);
        push("r0_bypass", 32'h22, 32'h99, 0, 2, 0, 1);

        // Hold with flush over three cycles: load r3 stays in stage 1.
        for (int i = 0; i < 3; i++) begin
            next_cycle(); hold = 1'b1; set_ex(1, 1, 1, 0, 5'd4); set_src(5'd3, 5'd4);
            set_stg(32'h33, 32'h44);
            push("hold", 32'h22, 32'h11, 0, 0, 1, 1);
        end
        next_cycle(); hold = 1'b0; set_ex(0, 0, 0, 0, 5'd0); set_src(5'd3, 5'd0);
        push("hold_release", 32'h22, 32'h11, 0, 0, 1, 1);
        next_cycle(); set_ex(1, 0, 1, 0, 5'd6); set_src(5'd3, 5'd0);
        push("load_after_hold", 32'h44, 32'h11, 2, 0, 0, 2);

        // Asynchronous reset mid-cycle discards the r6 tag at once.
        next_cycle(); set_ex(0, 0, 0, 0, 5'd0); set_src(5'd6, 5'd0); rst = 1'b1;
        push("async_rst", 32'h22, 32'h11, 0, 0, 0, 0);
        next_cycle(); rst = 1'b0;
        push("post_rst", 32'h22, 32'h11, 0, 0, 0, 0);

        // Flushed EX instruction leaves a bubble.
        next_cycle(); set_ex(1, 1, 1, 0, 5'd2); set_src(5'd0, 5'd0);
        push("flush_issue", 32'h22, 32'h11, 0, 0, 0, 0);
        next_cycle(); set_ex(0, 0, 0, 0, 5'd0); set_src(5'd2, 5'd0);
        push("flushed", 32'h22, 32'h11, 0, 0, 0, 0);

        next_cycle();
        @(negedge clk);
        #1;
        chk("sb_drain", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
